// File: rtl/div_pipe_spec_pkg.sv
// Shared types for the pipelined RV32M divider: the funct3 operation
// encoding, default geometry, register index types, and small decode helpers.
package div_pipe_spec_pkg;

  localparam int DFLT_XLEN      = 32;
  localparam int DFLT_STAGES    = 8;
  localparam int DFLT_ROB_BITS  = 5;
  localparam int DFLT_PREG_BITS = 6;
  localparam int DFLT_BRU_BITS  = 2;
  localparam int RREG_BITS      = 5;

  // Low two bits of the RV32M divide funct3 (100/101/110/111)
  typedef enum logic [1:0] {
    DIV_F3_DIV  = 2'b00,
    DIV_F3_DIVU = 2'b01,
    DIV_F3_REM  = 2'b10,
    DIV_F3_REMU = 2'b11
  } div_f3_t;

  typedef logic [RREG_BITS-1:0]      rreg_t;
  typedef logic [DFLT_PREG_BITS-1:0] preg_t;
  typedef logic [DFLT_ROB_BITS-1:0]  rob_idx_t;
  typedef logic [(2**DFLT_BRU_BITS)-1:0] br_mask_t;

  // DIV and REM interpret operands as two's complement
  function automatic logic op_is_signed(input div_f3_t op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder instead of the quotient
  function automatic logic op_is_rem(input div_f3_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_pipe_spec_iter_stage.sv
// One slice of the radix-2 restoring divider: K consecutive restoring steps,
// purely combinational. The dividend magnitude is consumed MSB first from
// dvd_i, and quotient bits are shifted into the LSB of quot_i.
module div_iter_stage #(
  parameter int XLEN = 32,
  parameter int K    = 4
) (
  input  logic [XLEN:0]   prem_i,
  input  logic [XLEN-1:0] dvd_i,
  input  logic [XLEN-1:0] dvs_i,
  input  logic [XLEN-1:0] quot_i,
  output logic [XLEN:0]   prem_o,
  output logic [XLEN-1:0] dvd_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0]   r;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] q;

  // K restoring steps: shift in the next dividend bit, trial-subtract the
  // divisor, keep the difference when it does not borrow. The partial
  // remainder stays below 2*divisor, so one extra bit is enough and the
  // difference MSB doubles as the borrow flag.
  always_comb begin
    r    = prem_i;
    d    = dvd_i;
    q    = quot_i;
    diff = '0;
    for (int s = 0; s < K; s++) begin
      r    = {r[XLEN-1:0], d[XLEN-1]};
      d    = {d[XLEN-2:0], 1'b0};
      diff = r - {1'b0, dvs_i};
      if (!diff[XLEN]) begin
        r = diff;
        q = {q[XLEN-2:0], 1'b1};
      end else begin
        q = {q[XLEN-2:0], 1'b0};
      end
    end
    prem_o = r;
    dvd_o  = d;
    quot_o = q;
  end

endmodule

// File: rtl/div_pipe_spec.sv
// Fully pipelined RV32M divider (DIV/DIVU/REM/REMU) for the out-of-order core.
// E0 latches operand magnitudes, sign/special-case flags and metadata; E1..E_STAGES
// each run XLEN/STAGES restoring steps; results are fixed up combinationally
// from the last stage. Entries carry branch masks for speculative kill.
// Optional feature macro: DIV_STALL_EN (CDB backpressure via out_ready).
//
// Handshake: an issue transfers on a cycle where issue_valid & issue_ready;
// a result transfers on a cycle where out_valid & out_ready. With DIV_STALL_EN
// undefined issue_ready is constantly 1 and the CDB must take every result.
module div_pipe_spec
  import div_pipe_spec_pkg::*;
#(
  parameter int  XLEN      = DFLT_XLEN,
  parameter int  STAGES    = DFLT_STAGES,
  parameter int  ROB_BITS  = DFLT_ROB_BITS,
  parameter int  PREG_BITS = DFLT_PREG_BITS,
  parameter int  BRU_BITS  = DFLT_BRU_BITS,
  localparam int NBR       = 2 ** BRU_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [XLEN-1:0]      issue_a,
  input  logic [XLEN-1:0]      issue_b,
  input  logic [1:0]           issue_op,
  input  logic [ROB_BITS-1:0]  issue_rob_idx,
  input  logic [4:0]           issue_rd,
  input  logic [PREG_BITS-1:0] issue_pd,
  input  logic [NBR-1:0]       issue_br_mask,
  input  logic                 br_valid,
  input  logic                 br_mispred,
  input  logic [BRU_BITS-1:0]  br_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_data,
  output logic [ROB_BITS-1:0]  out_rob_idx,
  output logic [4:0]           out_rd,
  output logic [PREG_BITS-1:0] out_pd,
  output logic [NBR-1:0]       out_br_mask
);

  localparam int K = XLEN / STAGES;

  if ((XLEN % STAGES) != 0) begin : g_bad_stages
    $error("div_pipe_spec: STAGES must divide XLEN evenly");
  end

  typedef struct packed {
    logic                 valid;
    div_f3_t              op;
    logic                 q_neg;
    logic                 r_neg;
    logic                 div0;
    logic                 ovf;
    logic [XLEN-1:0]      orig_a;  // kept for the divide-by-zero remainder
    logic [XLEN-1:0]      dvd;     // dividend magnitude bits not yet consumed
    logic [XLEN-1:0]      dvs;     // divisor magnitude
    logic [XLEN-1:0]      quot;
    logic [XLEN:0]        prem;    // partial remainder
    logic [ROB_BITS-1:0]  rob;
    rreg_t                rd;
    logic [PREG_BITS-1:0] pd;
    logic [NBR-1:0]       mask;
  } entry_t;

  // Mispredict kills dependent entries; a correct resolve frees the mask bit
  function automatic entry_t br_apply(input entry_t e, input logic bv,
                                      input logic bm, input logic [BRU_BITS-1:0] bi);
    entry_t r;
    r = e;
    if (bv) begin
      if (bm) begin
        if (e.mask[bi]) r.valid = 1'b0;
      end else begin
        r.mask[bi] = 1'b0;
      end
    end
    return r;
  endfunction

  entry_t e_q [0:STAGES];
  entry_t e_d [0:STAGES];
  entry_t cap;
  logic   advance;
  logic   is_signed;
  logic   a_neg;
  logic   b_neg;

  logic [XLEN:0]   st_prem [1:STAGES];
  logic [XLEN-1:0] st_dvd  [1:STAGES];
  logic [XLEN-1:0] st_quot [1:STAGES];

`ifdef DIV_STALL_EN
  // A full output slot that the CDB refuses freezes the whole pipe
  assign advance = ~out_valid | out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign advance          = 1'b1;
`endif

  assign issue_ready = advance;

  // Decode the incoming issue into an E0 entry
  always_comb begin
    cap        = '0;
    is_signed  = op_is_signed(div_f3_t'(issue_op));
    a_neg      = is_signed & issue_a[XLEN-1];
    b_neg      = is_signed & issue_b[XLEN-1];
    cap.valid  = issue_valid;
    cap.op     = div_f3_t'(issue_op);
    cap.q_neg  = a_neg ^ b_neg;
    cap.r_neg  = a_neg;
    cap.div0   = (issue_b == '0);
    cap.ovf    = is_signed & (issue_a == {1'b1, {(XLEN-1){1'b0}}}) & (&issue_b);
    cap.orig_a = issue_a;
    cap.dvd    = a_neg ? (~issue_a + 1'b1) : issue_a;
    cap.dvs    = b_neg ? (~issue_b + 1'b1) : issue_b;
    cap.quot   = '0;
    cap.prem   = '0;
    cap.rob    = issue_rob_idx;
    cap.rd     = issue_rd;
    cap.pd     = issue_pd;
    cap.mask   = issue_br_mask;
  end

  for (genvar gi = 1; gi <= STAGES; gi++) begin : g_iter
    div_iter_stage #(
      .XLEN (XLEN),
      .K    (K)
    ) u_iter (
      .prem_i (e_q[gi-1].prem),
      .dvd_i  (e_q[gi-1].dvd),
      .dvs_i  (e_q[gi-1].dvs),
      .quot_i (e_q[gi-1].quot),
      .prem_o (st_prem[gi]),
      .dvd_o  (st_dvd[gi]),
      .quot_o (st_quot[gi])
    );
  end

  // Shift the pipe when advancing, otherwise hold; branch updates always apply
  always_comb begin
    for (int i = 0; i <= STAGES; i++) e_d[i] = e_q[i];
    if (advance) begin
      e_d[0] = cap;
      for (int i = 1; i <= STAGES; i++) begin
        e_d[i]      = e_q[i-1];
        e_d[i].prem = st_prem[i];
        e_d[i].dvd  = st_dvd[i];
        e_d[i].quot = st_quot[i];
      end
    end
    for (int i = 0; i <= STAGES; i++) begin
      e_d[i] = br_apply(e_d[i], br_valid, br_mispred, br_idx);
    end
  end

  // Pipeline registers; reset only clears the valid bits
  always_ff @(posedge clk) begin
    for (int i = 0; i <= STAGES; i++) begin
      if (rst) e_q[i].valid <= 1'b0;
      else     e_q[i]       <= e_d[i];
    end
  end

  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  // Sign and special-case fixup of the final stage
  always_comb begin
    q_fix = e_q[STAGES].q_neg ? (~e_q[STAGES].quot + 1'b1) : e_q[STAGES].quot;
    r_fix = e_q[STAGES].r_neg ? (~e_q[STAGES].prem[XLEN-1:0] + 1'b1)
                              : e_q[STAGES].prem[XLEN-1:0];
    if (e_q[STAGES].div0) begin
      q_fix = '1;
      r_fix = e_q[STAGES].orig_a;
    end else if (e_q[STAGES].ovf) begin
      q_fix = {1'b1, {(XLEN-1){1'b0}}};
      r_fix = '0;
    end
    out_data = op_is_rem(e_q[STAGES].op) ? r_fix : q_fix;
  end

  assign out_valid   = e_q[STAGES].valid;
  assign out_rob_idx = e_q[STAGES].rob;
  assign out_rd      = e_q[STAGES].rd;
  assign out_pd      = e_q[STAGES].pd;
  assign out_br_mask = e_q[STAGES].mask;

endmodule

// File: tb/tb_div_pipe_spec.sv
// Directed bench for div_pipe_spec: reset state, latency, RV32M corner
// cases, back-to-back throughput, branch kill/clear, and (with DIV_STALL_EN)
// CDB backpressure and reset during a stall.
module tb_div_pipe_spec;

  localparam int XLEN = 32, STAGES = 8, ROB_BITS = 5, PREG_BITS = 6;
  localparam int BRU_BITS = 2, NBR = 4;
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 issue_valid, issue_ready;
  logic [XLEN-1:0]      issue_a, issue_b;
  logic [1:0]           issue_op;
  logic [ROB_BITS-1:0]  issue_rob_idx;
  logic [4:0]           issue_rd;
  logic [PREG_BITS-1:0] issue_pd;
  logic [NBR-1:0]       issue_br_mask;
  logic                 br_valid, br_mispred;
  logic [BRU_BITS-1:0]  br_idx;
  logic                 out_valid, out_ready;
  logic [XLEN-1:0]      out_data;
  logic [ROB_BITS-1:0]  out_rob_idx;
  logic [4:0]           out_rd;
  logic [PREG_BITS-1:0] out_pd;
  logic [NBR-1:0]       out_br_mask;

  // clock / reset
  always #5 clk = ~clk;

  div_pipe_spec #(
    .XLEN(XLEN), .STAGES(STAGES), .ROB_BITS(ROB_BITS),
    .PREG_BITS(PREG_BITS), .BRU_BITS(BRU_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_a(issue_a), .issue_b(issue_b), .issue_op(issue_op),
    .issue_rob_idx(issue_rob_idx), .issue_rd(issue_rd), .issue_pd(issue_pd),
    .issue_br_mask(issue_br_mask),
    .br_valid(br_valid), .br_mispred(br_mispred), .br_idx(br_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rob_idx(out_rob_idx), .out_rd(out_rd), .out_pd(out_pd),
    .out_br_mask(out_br_mask)
  );

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [ROB_BITS-1:0]  rob;
    logic [4:0]           rd;
    logic [PREG_BITS-1:0] pd;
    logic [NBR-1:0]       mask;
  } exp_t;

  exp_t exp_q[$];
  int   out_cyc_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   tag      = 0;
  int   n;
  exp_t mon_e;

  // hand-computed vectors
  logic [1:0] vop [16] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_DIV, OP_REM, OP_DIVU,
                           OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REM, OP_DIVU};
  logic [XLEN-1:0] va [16] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd7, 32'd5, 32'd5, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'hFFFF_FF9C, 32'd7, 32'h8000_0000};
  logic [XLEN-1:0] vb [16] = '{32'd7, 32'd7, 32'd2, 32'd2,
                               32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h10,
                               32'd2, 32'd7, 32'hFFFF_FFFE, 32'd3};
  logic [XLEN-1:0] vexp [16] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hF,
                                 32'hC000_0000, 32'hFFFF_FFFE, 32'd1, 32'h2AAA_AAAA};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  // scoreboard: every transferred result is compared with the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("out_meta", {out_rob_idx, out_rd, out_pd, out_br_mask},
            {mon_e.rob, mon_e.rd, mon_e.pd, mon_e.mask});
        out_cyc_q.push_back(cyc);
      end
    end
  end

  // driver: one cycle of issue/branch inputs, then the model update at the edge
  task automatic drive(input logic v, input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [NBR-1:0] m,
                       input logic [XLEN-1:0] ed, input logic bv, input logic bm,
                       input logic [BRU_BITS-1:0] bi);
    logic acc;
    exp_t e;
    issue_valid   = v;
    issue_op      = op;
    issue_a       = a;
    issue_b       = b;
    issue_br_mask = m;
    issue_rob_idx = 5'(tag);
    issue_rd      = 5'(tag * 3);
    issue_pd      = 6'(tag + 17);
    br_valid      = bv;
    br_mispred    = bm;
    br_idx        = bi;
    #1;
    acc = v & issue_ready;
    e   = '{data: ed, rob: 5'(tag), rd: 5'(tag * 3), pd: 6'(tag + 17), mask: m};
    if (v) tag++;
    @(posedge clk);
    if (acc) exp_q.push_back(e);
    if (bv) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        e = exp_q[i];
        if (bm) begin
          if (e.mask[bi]) exp_q.delete(i);
        end else begin
          e.mask[bi] = 1'b0;
          exp_q[i] = e;
        end
      end
    end
    #1;
    issue_valid = 1'b0;
    br_valid    = 1'b0;
    br_mispred  = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic drain(input string tg);
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      idle();
      k++;
    end
    chk(tg, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    issue_valid = 1'b0; issue_a = '0; issue_b = '0; issue_op = '0;
    issue_rob_idx = '0; issue_rd = '0; issue_pd = '0; issue_br_mask = '0;
    br_valid = 1'b0; br_mispred = 1'b0; br_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_issue_ready", issue_ready, 1'b1);
    rst = 1'b0;
    idle();
    chk("post_reset_out_valid", out_valid, 1'b0);

    // latency: result appears STAGES edges after the accepting edge
    drive(1'b1, vop[0], va[0], vb[0], '0, vexp[0], 1'b0, 1'b0, '0);
    n = 0;
    while (!out_valid && n < 50) begin
      idle();
      n++;
    end
    chk("latency", n, STAGES);
    drain("latency_drain");

    // 16 back-to-back issues covering signed, div0 and overflow cases
    out_cyc_q.delete();
    for (int i = 0; i < 16; i++) drive(1'b1, vop[i], va[i], vb[i], '0, vexp[i], 1'b0, 1'b0, '0);
    drain("burst_drain");
    chk("burst_count", out_cyc_q.size(), 16);
    chk("burst_one_per_cycle",
        (out_cyc_q.size() == 16) ? out_cyc_q[15] - out_cyc_q[0] : -1, 15);

    // branch resolve clears bit 1, then a reused bit 1 is mispredicted
    out_cyc_q.delete();
    for (int i = 0; i < 6; i++)
      drive(1'b1, vop[i], va[i], vb[i], (i % 2 == 0) ? 4'b0011 : 4'b0001, vexp[i],
            1'b0, 1'b0, '0);
    drive(1'b1, vop[6], va[6], vb[6], 4'b0010, vexp[6], 1'b1, 1'b0, 2'd1);
    for (int i = 7; i < 13; i++)
      drive(1'b1, vop[i], va[i], vb[i], (i % 2 == 1) ? 4'b0010 : 4'b0100, vexp[i],
            1'b0, 1'b0, '0);
    drive(1'b1, vop[13], va[13], vb[13], 4'b0010, vexp[13], 1'b1, 1'b1, 2'd1);
    drive(1'b1, vop[14], va[14], vb[14], 4'b0010, vexp[14], 1'b0, 1'b0, '0);
    drain("kill_drain");
    chk("kill_survivor_count", out_cyc_q.size(), 11);

`ifdef DIV_STALL_EN
    // fill the pipe with the CDB refusing, hold 5 cycles, then release
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) drive(1'b1, vop[i], va[i], vb[i], '0, vexp[i], 1'b0, 1'b0, '0);
    for (int s = 0; s < 5; s++) begin
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_issue_ready", issue_ready, 1'b0);
      chk("stall_out_data", out_data, vexp[0]);
      drive(1'b1, vop[9], va[9], vb[9], '0, vexp[9], 1'b0, 1'b0, '0);
    end
    out_ready = 1'b1;
    out_cyc_q.delete();
    drain("stall_drain");
    chk("stall_drain_count", out_cyc_q.size(), 9);

    // reset in the middle of a stall discards everything
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) drive(1'b1, vop[i], va[i], vb[i], '0, vexp[i], 1'b0, 1'b0, '0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_rst_out_valid", out_valid, 1'b0);
    chk("stall_rst_issue_ready", issue_ready, 1'b1);
    exp_q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
`endif

    // quiet tail: any leftover result would be flagged as spurious
    repeat (12) idle();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
